cic_sequencer: RTL and testbench

Control sequencer for the 3-stage CIC interpolator. It generates the enable, load and delay-update strobes, the zero-stuffing select, and the CIC synchronous clear from two free-running counters. It also pulls input samples from upstream with a ready/valid handshake and flags valid output samples. It sits between the sample source and the CIC datapath and owns all of that datapath's control pins.

---
 rtl/cic_sequencer.sv | 139 +++++++++++++
 tb/tb_cic_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cic_sequencer.sv
// Control sequencer for a 3-stage CIC interpolator: fast/slow strobes, zero-stuffing
// select, CIC clear and the upstream ready/valid sample handshake.
module cic_sequencer #(
    parameter int RATE         = 8,
    parameter int CLKS_PER_OUT = 4,
    parameter int WARMUP       = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_enable,
    input  logic i_sample_valid,
    output logic o_sample_ready,
    output logic o_cic_clear,
    output logic o_cic_en,
    output logic o_load_result_slow,
    output logic o_pulse_slow,
    output logic o_load_result_fast,
    output logic o_pulse_fast,
    output logic o_data_select,
    output logic o_out_valid,
    output logic o_underrun,
    output logic o_busy
);

    localparam int FW = $clog2(CLKS_PER_OUT);
    localparam int PW = $clog2(RATE);
    localparam logic [FW-1:0] FAST_LAST  = FW'(CLKS_PER_OUT - 1);
    localparam logic [FW-1:0] FAST_ONE   = FW'(1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(RATE - 1);
    localparam logic [3:0]    WARM_MAX   = 4'(WARMUP);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN} state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic [FW-1:0] r_fast_cnt;
    logic [PW-1:0] r_phase_cnt;
    logic [3:0]    r_warm_cnt;
    logic          r_inj;
    logic          r_underrun;

    logic w_run;
    logic w_slot;
    logic w_stop;
    logic w_take;
    logic w_miss;

    assign w_run  = (r_state == S_RUN);
    assign w_slot = w_run && (r_fast_cnt == '0) && (r_phase_cnt == PHASE_LAST);
    assign w_stop = w_slot && !i_enable;
    assign w_take = w_slot && i_enable && i_sample_valid;
    assign w_miss = w_slot && i_enable && !i_sample_valid;

    always_comb begin
        w_state_nx         = r_state;
        o_sample_ready     = 1'b0;
        o_cic_clear        = 1'b0;
        o_cic_en           = 1'b0;
        o_load_result_slow = 1'b0;
        o_pulse_slow       = 1'b0;
        o_load_result_fast = 1'b0;
        o_pulse_fast       = 1'b0;
        o_data_select      = 1'b0;
        o_out_valid        = 1'b0;
        o_busy             = 1'b1;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_enable)
                    w_state_nx = S_CLEAR;
            end
            S_CLEAR: begin
                o_cic_clear = 1'b1;
                w_state_nx  = S_RUN;
            end
            S_RUN: begin
                o_cic_en           = 1'b1;
                o_load_result_fast = (r_fast_cnt == '0) && !w_stop;
                o_pulse_fast       = (r_fast_cnt == FAST_ONE);
                o_out_valid        = (r_fast_cnt == FAST_ONE) && (r_warm_cnt == WARM_MAX);
                o_sample_ready     = w_slot && i_enable;
                o_load_result_slow = w_take;
                // r_inj is refreshed at the slot, so one cycle later it says whether a comb load happened
                o_pulse_slow       = (r_fast_cnt == FAST_ONE) && (r_phase_cnt == PHASE_LAST) && r_inj;
                o_data_select      = r_inj && (r_phase_cnt == '0);
                if (w_stop)
                    w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    assign o_underrun = r_underrun;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_fast_cnt  <= '0;
            r_phase_cnt <= '0;
            r_warm_cnt  <= '0;
            r_inj       <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            case (r_state)
                S_IDLE: begin
                    // cleared on entry so underrun already reads 0 during the clear cycle
                    if (i_enable)
                        r_underrun <= 1'b0;
                end
                S_CLEAR: begin
                    r_fast_cnt  <= '0;
                    r_phase_cnt <= PHASE_LAST;
                    r_warm_cnt  <= '0;
                    r_inj       <= 1'b0;
                end
                S_RUN: begin
                    if (r_fast_cnt == FAST_LAST) begin
                        r_fast_cnt  <= '0;
                        r_phase_cnt <= (r_phase_cnt == PHASE_LAST) ? '0 : r_phase_cnt + PW'(1);
                    end else begin
                        r_fast_cnt <= r_fast_cnt + FW'(1);
                    end
                    if (w_take) begin
                        r_inj <= 1'b1;
                        if (r_warm_cnt != WARM_MAX)
                            r_warm_cnt <= r_warm_cnt + 4'd1;
                    end
                    if (w_miss) begin
                        r_inj      <= 1'b0;
                        r_underrun <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cic_sequencer.sv
// Directed bench for cic_sequencer: two instances (8/4/3 and 2/2/3) share stimulus,
// scenario table selects which one is scored against closed-form cycle expectations.
module tb_cic_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;
    logic sv    = 1'b0;

    // bit order: ready, clear, cic_en, lrs, ps, lrf, pf, dsel, ovalid, underrun, busy
    logic a_sr, a_clr, a_en, a_lrs, a_ps, a_lrf, a_pf, a_ds, a_ov, a_ur, a_busy;
    logic b_sr, b_clr, b_en, b_lrs, b_ps, b_lrf, b_pf, b_ds, b_ov, b_ur, b_busy;
    logic [10:0] o8, o2;

    always #5 clk = ~clk;

    cic_sequencer #(.RATE(8), .CLKS_PER_OUT(4), .WARMUP(3)) u_r8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_sample_valid(sv),
        .o_sample_ready(a_sr), .o_cic_clear(a_clr), .o_cic_en(a_en),
        .o_load_result_slow(a_lrs), .o_pulse_slow(a_ps), .o_load_result_fast(a_lrf),
        .o_pulse_fast(a_pf), .o_data_select(a_ds), .o_out_valid(a_ov),
        .o_underrun(a_ur), .o_busy(a_busy)
    );

    cic_sequencer #(.RATE(2), .CLKS_PER_OUT(2), .WARMUP(3)) u_r2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_sample_valid(sv),
        .o_sample_ready(b_sr), .o_cic_clear(b_clr), .o_cic_en(b_en),
        .o_load_result_slow(b_lrs), .o_pulse_slow(b_ps), .o_load_result_fast(b_lrf),
        .o_pulse_fast(b_pf), .o_data_select(b_ds), .o_out_valid(b_ov),
        .o_underrun(b_ur), .o_busy(b_busy)
    );

    assign o8 = {a_sr, a_clr, a_en, a_lrs, a_ps, a_lrf, a_pf, a_ds, a_ov, a_ur, a_busy};
    assign o2 = {b_sr, b_clr, b_en, b_lrs, b_ps, b_lrf, b_pf, b_ds, b_ov, b_ur, b_busy};

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         sel;       // 0: RATE8/CLK4, 1: RATE2/CLK2
        int         stop_k;    // first RUN cycle index with enable low
        int         rst_k;     // RUN cycle index after which reset is pulsed (-1: none)
        bit         rel_rst;   // release reset at scenario start
        bit         u0;        // underrun expected in the starting idle cycle
        logic [7:0] vpat;      // sample_valid per slow period
        int         first_ov;  // expected first out_valid cycle index (-1: none)
        bit         ur_end;    // expected underrun at scenario end
    } scen_t;

    scen_t tbl[4];

    function automatic logic [10:0] pick(input int sel);
        return (sel != 0) ? o2 : o8;
    endfunction

    task automatic chk(input string nm, input logic [10:0] got, input logic [10:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic run_seq(input scen_t sc);
        int R, C, RC, first, s, ph, f, loads;
        bit done, urr, hit_rst;
        logic [10:0] e, g;
        logic last_ur;
        R = (sc.sel != 0) ? 2 : 8;
        C = (sc.sel != 0) ? 2 : 4;
        RC = R * C;
        first = -1;
        done = 1'b0;
        hit_rst = 1'b0;
        last_ur = 1'b0;

        @(negedge clk);
        if (sc.rel_rst) rst_n = 1'b1;
        en = 1'b1;
        sv = sc.vpat[0];
        #1;
        e = '0; e[1] = sc.u0;
        chk("idle_start", pick(sc.sel), e);

        @(negedge clk);
        #1;
        e = '0; e[9] = 1'b1; e[0] = 1'b1;
        chk("clear", pick(sc.sel), e);

        for (int k = 0; k < 2000 && !done; k++) begin
            @(negedge clk);
            s  = k / RC;
            ph = k % RC;
            f  = k % C;
            en = (k < sc.stop_k);
            sv = sc.vpat[s % 8];
            #1;
            g = pick(sc.sel);
            if (g[2] && first < 0) first = k;
            loads = 0;
            urr   = 1'b0;
            for (int j = 0; j <= s; j++) begin
                if (j < s || ph >= 1) begin
                    if (sc.vpat[j % 8]) loads++;
                    else urr = 1'b1;
                end
            end
            e = '0;
            e[8] = 1'b1;
            e[0] = 1'b1;
            e[1] = urr;
            if (ph == 0 && !en) begin
                chk("stop_slot", g, e);
                last_ur = g[1];
                done = 1'b1;
            end else begin
                e[10] = (ph == 0);
                e[7]  = (ph == 0) && sc.vpat[s % 8];
                e[6]  = (ph == 1) && sc.vpat[s % 8];
                e[5]  = (f == 0);
                e[4]  = (f == 1);
                e[3]  = sc.vpat[s % 8] && ph >= C && ph < 2 * C;
                e[2]  = (f == 1) && loads >= 3;
                chk("run", g, e);
            end
            if (k == sc.rst_k) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_async_r8", o8, '0);
                chk("rst_async_r2", o2, '0);
                last_ur = pick(sc.sel)[1];
                hit_rst = 1'b1;
                done = 1'b1;
            end
        end

        if (!done) begin
            total++;
            bad++;
            $display("FAIL timeout got=no_stop exp=stop_by_k%0d", sc.stop_k);
        end

        if (!hit_rst) begin
            repeat (6) begin
                @(negedge clk);
                en = 1'b0;
                #1;
                e = '0; e[1] = last_ur;
                chk("idle_tail", pick(sc.sel), e);
            end
        end

        total++;
        if (first != sc.first_ov) begin
            bad++;
            $display("FAIL first_out_valid got=%0d exp=%0d", first, sc.first_ov);
        end
        total++;
        if (last_ur !== sc.ur_end) begin
            bad++;
            $display("FAIL underrun_end got=%b exp=%b", last_ur, sc.ur_end);
        end
    endtask

    initial begin
        tbl[0] = '{sel: 0, stop_k: 138,  rst_k: -1, rel_rst: 1'b0, u0: 1'b0,
                   vpat: 8'hFF, first_ov: 65, ur_end: 1'b0};
        tbl[1] = '{sel: 0, stop_k: 100,  rst_k: -1, rel_rst: 1'b0, u0: 1'b0,
                   vpat: 8'hFD, first_ov: 97, ur_end: 1'b1};
        tbl[2] = '{sel: 0, stop_k: 1000, rst_k: 45, rel_rst: 1'b0, u0: 1'b1,
                   vpat: 8'hFF, first_ov: -1, ur_end: 1'b0};
        tbl[3] = '{sel: 1, stop_k: 20,   rst_k: -1, rel_rst: 1'b1, u0: 1'b0,
                   vpat: 8'hFF, first_ov: 9,  ur_end: 1'b0};

        rst_n = 1'b0;
        en = 1'b0;
        sv = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_r8", o8, '0);
        chk("reset_r2", o2, '0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++)
            run_seq(tbl[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
